// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage widths, state encoding and queue entry payload.
package instruction_fetch_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 40;
    localparam int unsigned PC_WIDTH          = 8;
    localparam int unsigned COUNT_WIDTH       = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_STALE = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] word;
        logic [PC_WIDTH-1:0]          pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry FIFO of fetched {word, pc}; flush overrides push and pop.
module instruction_fetch_queue
    import instruction_fetch_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           entry_i,
    output fetch_entry_t           head_o,
    output logic                   valid_o,
    output logic [COUNT_WIDTH-1:0] count_next_c
);

    fetch_entry_t           head_q, head_d;
    fetch_entry_t           tail_q, tail_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q;
    logic                   do_push, do_pop;

    // Next queue contents; a pop makes room for a push in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != COUNT_WIDTH'(0));
        do_push = push_i && ((count_q != COUNT_WIDTH'(2)) || do_pop);
        if (flush_i) begin
            count_d = COUNT_WIDTH'(0);
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == COUNT_WIDTH'(0)) head_d = entry_i;
                    else                            tail_d = entry_i;
                    count_d = count_q + COUNT_WIDTH'(1);
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - COUNT_WIDTH'(1);
                end
                2'b11: begin
                    if (count_q == COUNT_WIDTH'(1)) begin
                        head_d = entry_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Queue storage and registered valid flag.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= (count_d != COUNT_WIDTH'(0));
        end
    end

    assign head_o       = head_q;
    assign valid_o      = valid_q;
    assign count_next_c = count_d;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: pc, single-outstanding memory request FSM and output queue.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         run,
    input  logic                         redirect,
    input  logic [PC_WIDTH-1:0]          redirectPc,
    output logic                         memReq,
    output logic [PC_WIDTH-1:0]          memAddr,
    input  logic                         memAck,
    input  logic [INSTRUCTION_WIDTH-1:0] memData,
    output logic                         instructionValid,
    input  logic                         instructionReady,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instructionPc
);

    fetch_state_e           state_q;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   memReq_q;
    logic [PC_WIDTH-1:0]    memAddr_q;
    logic                   ack_live, push, pop, issue;
    logic [COUNT_WIDTH-1:0] count_next;
    fetch_entry_t           entry, head;

    // Live ack enqueues unless a redirect drops it; issue uses post-update occupancy.
    always_comb begin
        ack_live = (state_q == FETCH_REQ) && memAck;
        push     = ack_live && !redirect;
        pop      = instructionValid && instructionReady;
        entry    = '{word: memData, pc: memAddr_q};
        if (redirect)      pc_d = redirectPc;
        else if (ack_live) pc_d = pc_q + PC_WIDTH'(1);
        else               pc_d = pc_q;
        issue = run && (count_next < COUNT_WIDTH'(2));
    end

    // Request FSM: a redirect during an outstanding request marks it stale.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                FETCH_IDLE: begin
                    if (issue) begin
                        state_q   <= FETCH_REQ;
                        memReq_q  <= 1'b1;
                        memAddr_q <= pc_d;
                    end
                end
                FETCH_REQ, FETCH_STALE: begin
                    if (memAck) begin
                        if (issue) begin
                            state_q   <= FETCH_REQ;
                            memReq_q  <= 1'b1;
                            memAddr_q <= pc_d;
                        end else begin
                            state_q  <= FETCH_IDLE;
                            memReq_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        state_q <= FETCH_STALE;
                    end
                end
                default: begin
                    state_q  <= FETCH_IDLE;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end

    instruction_fetch_queue u_queue (
        .clock        (clock),
        .resetN       (resetN),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect),
        .entry_i      (entry),
        .head_o       (head),
        .valid_o      (instructionValid),
        .count_next_c (count_next)
    );

    assign memReq        = memReq_q;
    assign memAddr       = memAddr_q;
    assign instruction   = head.word;
    assign instructionPc = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a latency-programmable memory model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic                         clock = 1'b0;
    logic                         resetN = 1'b0;
    logic                         run = 1'b0;
    logic                         redirect = 1'b0;
    logic [PC_WIDTH-1:0]          redirectPc = '0;
    logic                         memReq;
    logic [PC_WIDTH-1:0]          memAddr;
    logic                         memAck = 1'b0;
    logic [INSTRUCTION_WIDTH-1:0] memData = '0;
    logic                         instructionValid;
    logic                         instructionReady = 1'b0;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]          instructionPc;

    int n_compared = 0;
    int n_mismatched = 0;
    int lat = 0;
    int wait_cnt = 0;
    int ack_count = 0;
    logic [PC_WIDTH-1:0] sb[$];

    instruction_fetch #(.RESET_PC(8'h10)) dut (
        .clock            (clock),
        .resetN           (resetN),
        .run              (run),
        .redirect         (redirect),
        .redirectPc       (redirectPc),
        .memReq           (memReq),
        .memAddr          (memAddr),
        .memAck           (memAck),
        .memData          (memData),
        .instructionValid (instructionValid),
        .instructionReady (instructionReady),
        .instruction      (instruction),
        .instructionPc    (instructionPc)
    );

    always #5 clock = ~clock;

    function automatic logic [INSTRUCTION_WIDTH-1:0] mem_word(input logic [PC_WIDTH-1:0] a);
        return {16'hBEEF, a, ~a, a ^ 8'hA5};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory: acks after 'lat' waiting cycles of a held request.
    always @(negedge clock) begin
        if (memReq) begin
            if (wait_cnt >= lat) begin
                memAck   = 1'b1;
                memData  = mem_word(memAddr);
                wait_cnt = 0;
                ack_count++;
            end else begin
                memAck = 1'b0;
                wait_cnt++;
            end
        end else begin
            memAck   = 1'b0;
            wait_cnt = 0;
        end
    end

    // Consumer side: every accepted word is checked against the scoreboard.
    always @(negedge clock) begin
        #1;
        if (resetN && instructionValid && instructionReady) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                logic [PC_WIDTH-1:0] exp_pc;
                exp_pc = sb.pop_front();
                check_eq("head_pc", 64'(instructionPc), 64'(exp_pc));
                check_eq("head_word", 64'(instruction), 64'(mem_word(exp_pc)));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetN = 1'b0;
        run = 1'b0;
        instructionReady = 1'b0;
        redirect = 1'b0;
        redirectPc = '0;
        repeat (2) @(negedge clock);
        sb.delete();
    endtask

    task automatic push_range(input logic [PC_WIDTH-1:0] start, input int n);
        logic [PC_WIDTH-1:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back(p);
            p = p + 8'd1;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check_eq(tag, 64'(sb.size()), 64'd0);
        instructionReady = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Reset values
        do_reset();
        check_eq("rst_memReq", 64'(memReq), 64'd0);
        check_eq("rst_memAddr", 64'(memAddr), 64'd0);
        check_eq("rst_valid", 64'(instructionValid), 64'd0);
        check_eq("rst_instruction", 64'(instruction), 64'd0);
        check_eq("rst_instructionPc", 64'(instructionPc), 64'd0);

        // Streaming from RESET_PC at one word per cycle
        lat = 0;
        run = 1'b1;
        instructionReady = 1'b1;
        push_range(8'h10, 8);
        resetN = 1'b1;
        cyc = 0;
        while (!instructionValid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("first_valid_latency", 64'(cyc), 64'd2);
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("stream_cycles", 64'(cyc), 64'd8);
        instructionReady = 1'b0;
        run = 1'b0;

        // Backpressure: two words queue up, then fetch resumes at pc+2
        do_reset();
        lat = 0;
        run = 1'b1;
        ack_count = 0;
        resetN = 1'b1;
        repeat (8) @(negedge clock);
        check_eq("full_memReq", 64'(memReq), 64'd0);
        check_eq("full_ack_count", 64'(ack_count), 64'd2);
        check_eq("full_valid", 64'(instructionValid), 64'd1);
        check_eq("full_head_pc", 64'(instructionPc), 64'h10);
        push_range(8'h10, 6);
        instructionReady = 1'b1;
        wait_drain("drain_backpressure", 60);

        // Redirect while a slow request is pending: its data is dropped
        do_reset();
        resetN = 1'b1;
        redirect = 1'b1;
        redirectPc = 8'h05;
        @(negedge clock);
        redirect = 1'b0;
        run = 1'b1;
        lat = 3;
        instructionReady = 1'b1;
        push_range(8'h40, 3);
        @(negedge clock);
        check_eq("pending_memReq", 64'(memReq), 64'd1);
        check_eq("pending_memAddr", 64'(memAddr), 64'h05);
        redirect = 1'b1;
        redirectPc = 8'h40;
        @(negedge clock);
        redirect = 1'b0;
        check_eq("stale_memReq", 64'(memReq), 64'd1);
        check_eq("stale_memAddr", 64'(memAddr), 64'h05);
        wait_drain("drain_stale", 80);
        lat = 0;

        // Redirect together with ack and pop: queue flushed, ack dropped
        do_reset();
        lat = 0;
        run = 1'b1;
        resetN = 1'b1;
        repeat (6) @(negedge clock);
        sb.push_back(8'h10);
        sb.push_back(8'h11);
        push_range(8'h80, 3);
        instructionReady = 1'b1;
        @(negedge clock);
        check_eq("pre_redirect_memAddr", 64'(memAddr), 64'h12);
        redirect = 1'b1;
        redirectPc = 8'h80;
        @(negedge clock);
        redirect = 1'b0;
        check_eq("flush_valid", 64'(instructionValid), 64'd0);
        check_eq("flush_memReq", 64'(memReq), 64'd1);
        check_eq("flush_memAddr", 64'(memAddr), 64'h80);
        wait_drain("drain_flush", 40);

        // PC wraps from 0xFF to 0x00
        do_reset();
        resetN = 1'b1;
        redirect = 1'b1;
        redirectPc = 8'hFE;
        @(negedge clock);
        redirect = 1'b0;
        lat = 0;
        run = 1'b1;
        instructionReady = 1'b1;
        sb.push_back(8'hFE);
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        sb.push_back(8'h01);
        wait_drain("drain_wrap", 40);

        // Reset during an outstanding request, then a late ack
        do_reset();
        lat = 2;
        run = 1'b1;
        resetN = 1'b1;
        @(negedge clock);
        check_eq("midreq_memReq", 64'(memReq), 64'd1);
        check_eq("midreq_memAddr", 64'(memAddr), 64'h10);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("async_rst_memReq", 64'(memReq), 64'd0);
        @(negedge clock);
        #2;
        resetN = 1'b1;
        run = 1'b0;
        memAck = 1'b1;
        memData = 40'hDEAD_BEEF_01;
        @(negedge clock);
        #2;
        check_eq("late_ack_valid", 64'(instructionValid), 64'd0);
        check_eq("late_ack_memReq", 64'(memReq), 64'd0);
        check_eq("late_ack_memAddr", 64'(memAddr), 64'd0);
        check_eq("late_ack_instructionPc", 64'(instructionPc), 64'd0);
        check_eq("late_ack_instruction", 64'(instruction), 64'd0);
        repeat (3) @(negedge clock);
        check_eq("late_ack_valid_hold", 64'(instructionValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
